scalar_fpdivsqrt_arbiter: RTL and testbench
===========================================

# scalar_fpdivsqrt_arbiter

Shares a single `scalar_fpdivsqrt` unit between `NUM_REQ` requesters, such as issue ports or lanes. The block round-robin arbitrates start requests and forwards the winner's operands to the divider unchanged. It records the owner and tag of the single in-flight operation. A one-entry response buffer returns the result to its owner, so the divider can accept the next operation before the previous result has been consumed.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `TAG_W`, default 5: width of the requester-supplied tag, echoed back with the result.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `flush_i` input, 1 bit: synchronous kill of the in-flight operation and the buffered response.
- `req_valid_i` input, `NUM_REQ` bits: per-requester start request.
- `req_ready_o` output, `NUM_REQ` bits: per-requester grant; an operation is accepted on `valid & ready`.
- `req_fp_format_i` input, `NUM_REQ*3` bits: one-hot format per requester ([0] f16, [1] f32, [2] f64).
- `req_is_fdiv_i` input, `NUM_REQ` bits: 1 selects div, 0 selects sqrt.
- `req_opa_i`, `req_opb_i` input, `NUM_REQ*64` bits each: operands, laid out as the divider expects.
- `req_rm_i` input, `NUM_REQ*3` bits: rounding mode.
- `req_tag_i` input, `NUM_REQ*TAG_W` bits: tag per requester.
- `div_start_valid_o` output, 1 bit; `div_start_ready_i` input, 1 bit: divider start handshake.
- `div_fp_format_o` (3), `div_is_fdiv_o` (1), `div_opa_o` (64), `div_opb_o` (64), `div_rm_o` (3): outputs carrying the muxed operation.
- `div_flush_o` output, 1 bit: flush to the divider.
- `div_finish_valid_i` input, 1 bit; `div_finish_ready_o` output, 1 bit: divider finish handshake.
- `div_res_i` input, 64 bits; `div_fflags_i` input, 5 bits: result and exception flags from the divider.
- `resp_valid_o` output, `NUM_REQ` bits: one-hot; asserted only for the owner of the buffered result.
- `resp_ready_i` input, `NUM_REQ` bits: per-requester accept.
- `resp_res_o` (64), `resp_fflags_o` (5), `resp_tag_o` (`TAG_W`) outputs: shared response bus, valid wherever any `resp_valid_o` bit is set.

## Operation
- **Issue FSM.** Two states, IDLE and BUSY.
  - IDLE: `div_start_valid_o = |req_valid_i & !flush_i`. The grant index `g` is the first requester with valid set, searching from `rr_ptr` upward and wrapping.
  - `div_*` outputs are muxed from requester `g` combinationally.
  - `req_ready_o[g] = div_start_ready_i & !flush_i`; every other bit is 0.
  - On a handshake: `owner_q <= g`, `tag_q <= req_tag_i[g]`, `rr_ptr <= (g+1) mod NUM_REQ`, and the FSM moves to BUSY.
  - BUSY: `div_start_valid_o = 0` and all `req_ready_o` are 0.
  - `div_finish_ready_o = !resp_full | resp_pop`, where `resp_pop = resp_valid_o[resp_owner] & resp_ready_i[resp_owner]`.
  - On a finish handshake, the buffer loads `res`, `fflags`, `owner_q` and `tag_q`, and the FSM returns to IDLE.
- **Response buffer.** One entry.
  - `resp_full` sets on a finish handshake and clears on `resp_pop`.
  - A pop and a load in the same cycle leave the buffer full with the new data.
  - `resp_valid_o = resp_full ? (1 << resp_owner) : 0`.
- **Requester fairness.**
  - Only grants move `rr_ptr`.
  - Requester valid may drop before a grant; no requester state is kept.
- **Flush** (has priority over every other event in the same cycle):
  - `div_flush_o = flush_i`.
  - The FSM goes to IDLE and `resp_full` clears.
  - A finish handshake that coincides with the flush is discarded.
  - `rr_ptr` is unchanged.
- **Reset values:**
  - FSM IDLE, `rr_ptr = 0`, `resp_full = 0`.
  - All `req_ready_o`, `resp_valid_o`, `div_start_valid_o` and `div_flush_o` are 0; `div_finish_ready_o` is 1.
  - `resp_res_o`, `resp_fflags_o` and `resp_tag_o` are 0.

## Timing
- Issue path is combinational: a request presented in IDLE reaches the divider in the same cycle.
- Response path is registered: `resp_valid_o` rises one cycle after the finish handshake.
- Back-to-back operation: a new start can be granted in the cycle after a finish handshake (FSM back in IDLE), while the previous response is still buffered.
- When the buffer is full and unconsumed, `div_finish_ready_o = 0`. The divider holds its result, and the FSM stays in BUSY.
- At most one operation is in the divider and at most one is in the buffer.
- Reset asserted mid-operation returns every register to its reset value asynchronously. The divider shares `rst_n`.

## Test plan
- **Single f64 div, requester 2.** Inputs: `opa = 0x3FF0000000000000`, `opb = 0x4000000000000000`, `rm = 0`, `tag = 5`.
  - Response: `resp_valid_o = 4'b0100`, `res = 0x3FE0000000000000`, `fflags = 0`, `tag = 5`.
  - After the grant, `rr_ptr = 3`.
- **All 4 requesters valid continuously, f32 sqrt `0x40800000`.** Grants go in order 0, 1, 2, 3, 0. Each response is `0x40000000` routed to the matching requester.
- **Back-to-back with response stall.**
  - Setup: req0 holds `resp_ready = 0` while req1 issues.
  - `div_finish_ready_o` is 0 when the req1 result arrives, and is held until req0 accepts.
  - After req0 accepts, req1's result appears one cycle later.
- **Flush during BUSY, and flush coincident with finish valid.**
  - `div_flush_o` pulses for one cycle, `resp_valid_o = 0`, and the FSM is IDLE.
  - The next request is granted the following cycle.
- **Async reset mid-BUSY, with a full buffer.**
  - All outputs take their reset values immediately.
  - After release, the next grant goes to requester 0.
- **Divide by zero, f16.** Inputs: `opa = 0x3C00`, `opb = 0x0000`.
  - Response: `res = 0x7C00`, `fflags = 5'b01000` (DZ), and the tag is echoed intact.

Source files
------------

// File: rtl/scalar_fpdivsqrt_arbiter.sv
// Shares one scalar_fpdivsqrt unit between NUM_REQ requesters.
// Round-robin start arbitration, one operation in flight, and a
// one-entry response buffer so the divider can start the next
// operation before the previous result has been consumed.
module scalar_fpdivsqrt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*3-1:0]     req_fp_format_i,
  input  logic [NUM_REQ-1:0]       req_is_fdiv_i,
  input  logic [NUM_REQ*64-1:0]    req_opa_i,
  input  logic [NUM_REQ*64-1:0]    req_opb_i,
  input  logic [NUM_REQ*3-1:0]     req_rm_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  output logic                     div_start_valid_o,
  input  logic                     div_start_ready_i,
  output logic [2:0]               div_fp_format_o,
  output logic                     div_is_fdiv_o,
  output logic [63:0]              div_opa_o,
  output logic [63:0]              div_opb_o,
  output logic [2:0]               div_rm_o,
  output logic                     div_flush_o,
  input  logic                     div_finish_valid_i,
  output logic                     div_finish_ready_o,
  input  logic [63:0]              div_res_i,
  input  logic [4:0]               div_fflags_i,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  input  logic [NUM_REQ-1:0]       resp_ready_i,
  output logic [63:0]              resp_res_o,
  output logic [4:0]               resp_fflags_o,
  output logic [TAG_W-1:0]         resp_tag_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]   owner_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [PTR_W-1:0]   grant_idx;
  logic               any_valid;
  logic               start_fire;
  logic               finish_fire;
  logic               resp_pop;

  logic               resp_full_reg;
  logic [PTR_W-1:0]   resp_owner_reg;
  logic [63:0]        resp_res_reg;
  logic [4:0]         resp_fflags_reg;
  logic [TAG_W-1:0]   resp_tag_reg;

  logic [2:0]         fmt_arr [NUM_REQ];
  logic               is_fdiv_arr [NUM_REQ];
  logic [63:0]        opa_arr [NUM_REQ];
  logic [63:0]        opb_arr [NUM_REQ];
  logic [2:0]         rm_arr [NUM_REQ];
  logic [TAG_W-1:0]   tag_arr [NUM_REQ];

  // Index `off` steps above `base`, wrapping at NUM_REQ (not necessarily a power of two).
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign fmt_arr[gi]     = req_fp_format_i[gi*3 +: 3];
      assign is_fdiv_arr[gi] = req_is_fdiv_i[gi];
      assign opa_arr[gi]     = req_opa_i[gi*64 +: 64];
      assign opb_arr[gi]     = req_opb_i[gi*64 +: 64];
      assign rm_arr[gi]      = req_rm_i[gi*3 +: 3];
      assign tag_arr[gi]     = req_tag_i[gi*TAG_W +: TAG_W];
    end
  endgenerate

  // Round-robin search: walk offsets from the far end down so the closest valid requester wins.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[wrap_add(rr_ptr_reg, i)]) begin
        grant_idx = wrap_add(rr_ptr_reg, i);
        any_valid = 1'b1;
      end
    end
  end

  // The winner's operands go to the divider unchanged, same cycle.
  assign div_fp_format_o = fmt_arr[grant_idx];
  assign div_is_fdiv_o   = is_fdiv_arr[grant_idx];
  assign div_opa_o       = opa_arr[grant_idx];
  assign div_opb_o       = opb_arr[grant_idx];
  assign div_rm_o        = rm_arr[grant_idx];
  assign div_flush_o     = flush_i;

  assign resp_pop           = resp_full_reg & resp_ready_i[resp_owner_reg];
  assign div_finish_ready_o = ~resp_full_reg | resp_pop;
  assign finish_fire        = (state_reg == BUSY) & div_finish_valid_i & div_finish_ready_o & ~flush_i;

  // Issue FSM next state and start handshake; flush overrides everything.
  always_comb begin
    state_next        = state_reg;
    rr_ptr_next       = rr_ptr_reg;
    div_start_valid_o = 1'b0;
    req_ready_o       = '0;
    start_fire        = 1'b0;
    case (state_reg)
      IDLE: begin
        div_start_valid_o = any_valid & ~flush_i;
        if (any_valid) req_ready_o[grant_idx] = div_start_ready_i & ~flush_i;
        start_fire = any_valid & ~flush_i & div_start_ready_i;
        if (start_fire) begin
          state_next  = BUSY;
          rr_ptr_next = wrap_add(grant_idx, 1);
        end
      end
      BUSY: begin
        if (finish_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  // FSM state, fairness pointer and the owner/tag of the operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
      tag_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (start_fire) begin
        owner_reg <= grant_idx;
        tag_reg   <= tag_arr[grant_idx];
      end
    end
  end

  // One-entry response buffer; a load wins over a simultaneous pop, flush wins over both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_full_reg   <= 1'b0;
      resp_owner_reg  <= '0;
      resp_res_reg    <= '0;
      resp_fflags_reg <= '0;
      resp_tag_reg    <= '0;
    end else if (flush_i) begin
      resp_full_reg <= 1'b0;
    end else if (finish_fire) begin
      resp_full_reg   <= 1'b1;
      resp_owner_reg  <= owner_reg;
      resp_res_reg    <= div_res_i;
      resp_fflags_reg <= div_fflags_i;
      resp_tag_reg    <= tag_reg;
    end else if (resp_pop) begin
      resp_full_reg <= 1'b0;
    end
  end

  // Response valid is one-hot on the buffered owner.
  always_comb begin
    resp_valid_o = '0;
    if (resp_full_reg) resp_valid_o[resp_owner_reg] = 1'b1;
  end

  assign resp_res_o    = resp_res_reg;
  assign resp_fflags_o = resp_fflags_reg;
  assign resp_tag_o    = resp_tag_reg;

endmodule

// File: tb/tb_scalar_fpdivsqrt_arbiter.sv
// Bench for scalar_fpdivsqrt_arbiter: behavioural divider stand-in,
// scoreboard of expected responses, table of grant vectors and
// hand-written sequences for stall, flush and async reset.
`timescale 1ns/1ps
module tb_scalar_fpdivsqrt_arbiter;
  localparam int N  = 4;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_rdy = '1;
  logic [2:0]      fmt_a [N];
  logic            isdiv_a [N];
  logic [63:0]     opa_a [N];
  logic [63:0]     opb_a [N];
  logic [2:0]      rm_a [N];
  logic [TW-1:0]   tag_a [N];
  logic [N*3-1:0]  fmt_f, rm_f;
  logic [N-1:0]    isdiv_f;
  logic [N*64-1:0] opa_f, opb_f;
  logic [N*TW-1:0] tag_f;

  logic        div_start_valid, div_start_ready, div_is_fdiv, div_flush;
  logic        div_finish_valid, div_finish_ready;
  logic [2:0]  div_fmt, div_rm;
  logic [63:0] div_opa, div_opb, div_res, resp_res;
  logic [4:0]  div_ff, resp_ff;
  logic [TW-1:0] resp_tag;

  always_comb begin
    fmt_f = '0; rm_f = '0; isdiv_f = '0; opa_f = '0; opb_f = '0; tag_f = '0;
    for (int r = 0; r < N; r++) begin
      fmt_f[r*3 +: 3]   = fmt_a[r];
      rm_f[r*3 +: 3]    = rm_a[r];
      isdiv_f[r]        = isdiv_a[r];
      opa_f[r*64 +: 64] = opa_a[r];
      opb_f[r*64 +: 64] = opb_a[r];
      tag_f[r*TW +: TW] = tag_a[r];
    end
  end

  scalar_fpdivsqrt_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_fp_format_i(fmt_f), .req_is_fdiv_i(isdiv_f),
    .req_opa_i(opa_f), .req_opb_i(opb_f), .req_rm_i(rm_f), .req_tag_i(tag_f),
    .div_start_valid_o(div_start_valid), .div_start_ready_i(div_start_ready),
    .div_fp_format_o(div_fmt), .div_is_fdiv_o(div_is_fdiv),
    .div_opa_o(div_opa), .div_opb_o(div_opb), .div_rm_o(div_rm),
    .div_flush_o(div_flush),
    .div_finish_valid_i(div_finish_valid), .div_finish_ready_o(div_finish_ready),
    .div_res_i(div_res), .div_fflags_i(div_ff),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_rdy),
    .resp_res_o(resp_res), .resp_fflags_o(resp_ff), .resp_tag_o(resp_tag)
  );

  // Divider stand-in: known IEEE cases from the test plan, otherwise a field scramble.
  function automatic logic [68:0] div_model(input logic [2:0] f, input logic d,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] r);
    if (d && f == 3'b100 && a == 64'h3FF0000000000000 && b == 64'h4000000000000000)
      return {5'b00000, 64'h3FE0000000000000};
    if (!d && f == 3'b010 && a == 64'h0000000040800000)
      return {5'b00000, 64'h0000000040000000};
    if (d && f == 3'b001 && a == 64'h3C00 && b == 64'h0)
      return {5'b01000, 64'h7C00};
    return {r, f[1:0] ^ {1'b0, d}, a ^ {b[31:0], b[63:32]} ^ {57'd0, d, r, f}};
  endfunction

  int          dv_lat = 2;
  logic        dv_busy;
  int          dv_cnt;
  logic [68:0] dv_rf;
  assign div_start_ready  = !dv_busy;
  assign div_finish_valid = dv_busy && (dv_cnt == 0);
  assign div_res          = dv_rf[63:0];
  assign div_ff           = dv_rf[68:64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_busy <= 1'b0; dv_cnt <= 0; dv_rf <= '0;
    end else if (div_flush) begin
      dv_busy <= 1'b0;
    end else if (!dv_busy) begin
      if (div_start_valid) begin
        dv_busy <= 1'b1; dv_cnt <= dv_lat;
        dv_rf   <= div_model(div_fmt, div_is_fdiv, div_opa, div_opb, div_rm);
      end
    end else if (dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1;
    end else if (div_finish_ready) begin
      dv_busy <= 1'b0;
    end
  end

  typedef struct {
    int          owner;
    logic [68:0] rf;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [N-1:0] mask;
    int           exp_g;
  } vec_t;
  vec_t tbl[7];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every accepted response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush_i && ((resp_valid & resp_rdy) != '0)) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 128'(resp_valid), 128'(0));
      end else begin
        e = sb.pop_front();
        check("resp_owner", 128'(resp_valid), 128'(1) << e.owner);
        check("resp_data", {resp_ff, resp_res, resp_tag}, {e.rf, e.tag});
        $display("resp  owner=%0d tag=%0h res=%016h fflags=%05b", e.owner, resp_tag, resp_res, resp_ff);
      end
    end
  end

  task automatic set_req(input int r, input logic [2:0] f, input logic d, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] rm, input logic [TW-1:0] t);
    fmt_a[r] = f; isdiv_a[r] = d; opa_a[r] = a; opb_a[r] = b; rm_a[r] = rm; tag_a[r] = t;
  endtask

  task automatic rand_req(input int r);
    logic [2:0] f;
    f = 3'b001 << $urandom_range(0, 2);
    set_req(r, f, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            3'($urandom_range(0, 4)), TW'($urandom));
  endtask

  // Optionally drive a request mask, wait for the start handshake, check grant and mux, push expectation.
  task automatic issue(input logic [N-1:0] mask, input int g, input bit drive, input bit hold,
                       input int maxw, input string name);
    int n;
    n = 0;
    if (drive) begin
      @(posedge clk); #1;
      req_valid = mask;
    end
    @(negedge clk);
    while (!(div_start_valid && div_start_ready) && n < maxw) begin
      @(negedge clk);
      n++;
    end
    check({name, "_hs"}, 128'(div_start_valid & div_start_ready), 128'(1));
    check({name, "_grant"}, 128'(req_ready), 128'(1) << g);
    check({name, "_opa"}, 128'(div_opa), 128'(opa_a[g]));
    check({name, "_opb"}, 128'(div_opb), 128'(opb_a[g]));
    check({name, "_ctl"}, 128'({div_fmt, div_is_fdiv, div_rm}), 128'({fmt_a[g], isdiv_a[g], rm_a[g]}));
    sb.push_back('{owner: g, rf: div_model(fmt_a[g], isdiv_a[g], opa_a[g], opb_a[g], rm_a[g]), tag: tag_a[g]});
    $display("grant %s req=%0d tag=%0h", name, g, tag_a[g]);
    @(posedge clk); #1;
    if (!hold) req_valid = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || resp_valid != '0) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_drained"}, 128'(sb.size()), 128'(0));
    sb.delete();
  endtask

  task automatic wait_resp(input logic [N-1:0] mask, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (resp_valid != mask && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(resp_valid), 128'(mask));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, 128'(req_ready), 128'(0));
    check({name, "_resp_valid"}, 128'(resp_valid), 128'(0));
    check({name, "_start_valid"}, 128'(div_start_valid), 128'(0));
    check({name, "_div_flush"}, 128'(div_flush), 128'(0));
    check({name, "_finish_ready"}, 128'(div_finish_ready), 128'(1));
    check({name, "_resp_bus"}, {resp_res, resp_ff, resp_tag}, 128'(0));
  endtask

  initial begin
    int n;
    // Grant vectors starting from rr_ptr = 3.
    tbl[0] = '{4'b1001, 3};
    tbl[1] = '{4'b0110, 1};
    tbl[2] = '{4'b0011, 0};
    tbl[3] = '{4'b1111, 1};
    tbl[4] = '{4'b1010, 3};
    tbl[5] = '{4'b0100, 2};
    tbl[6] = '{4'b0001, 0};
    for (int r = 0; r < N; r++) rand_req(r);

    #3;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All requesters valid continuously: f32 sqrt 4.0.
    for (int r = 0; r < N; r++) set_req(r, 3'b010, 1'b0, 64'h40800000, 64'h0, 3'd0, TW'(10 + r));
    for (int k = 0; k < 5; k++) issue(4'b1111, k % N, 1'b1, 1'b1, 50, "rr_all");
    req_valid = '0;
    for (int k = 0; k < 5; k++) check("rr_all_res", 128'(div_model(3'b010, 1'b0, 64'h40800000, 64'h0, 3'd0)), 128'({5'b0, 64'h40000000}));
    drain("rr_all");

    // Single f64 div on requester 2; next table vector proves rr_ptr = 3.
    set_req(2, 3'b100, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 3'd0, 5'd5);
    issue(4'b0100, 2, 1'b1, 1'b0, 50, "f64_div");
    check("f64_div_exp", 128'(sb[0].rf), 128'({5'b0, 64'h3FE0000000000000}));
    wait_resp(4'b0100, "f64_div_valid");
    drain("f64_div");

    // Table-driven grant vectors with random operands.
    for (int v = 0; v < 7; v++) begin
      for (int r = 0; r < N; r++) rand_req(r);
      issue(tbl[v].mask, tbl[v].exp_g, 1'b1, 1'b0, 50, $sformatf("tbl%0d", v));
      drain($sformatf("tbl%0d", v));
    end

    // Back-to-back with req0 stalling its response.
    for (int r = 0; r < N; r++) rand_req(r);
    resp_rdy = 4'b1110;
    issue(4'b0001, 0, 1'b1, 1'b0, 50, "stall_r0");
    wait_resp(4'b0001, "stall_r0_buffered");
    issue(4'b0010, 1, 1'b1, 1'b0, 50, "stall_r1");
    n = 0;
    @(negedge clk);
    while (!div_finish_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      check("stall_finish_ready", 128'(div_finish_ready), 128'(0));
      check("stall_hold_valid", 128'(resp_valid), 128'(4'b0001));
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_rdy = '1;
    @(negedge clk);
    check("stall_pop_ready", 128'(div_finish_ready), 128'(1));
    @(negedge clk);
    check("stall_r1_next", 128'(resp_valid), 128'(4'b0010));
    drain("stall");

    // Flush during BUSY with another request waiting.
    dv_lat = 10;
    for (int r = 0; r < N; r++) rand_req(r);
    issue(4'b0100, 2, 1'b1, 1'b0, 50, "flush_busy");
    @(posedge clk); #1;
    flush_i = 1'b1;
    req_valid = 4'b1000;
    @(negedge clk);
    check("flush_pulse", 128'(div_flush), 128'(1));
    check("flush_no_start", 128'(div_start_valid), 128'(0));
    check("flush_no_ready", 128'(req_ready), 128'(0));
    @(posedge clk); #1;
    flush_i = 1'b0;
    sb.delete();
    #1;
    check("flush_pulse_end", 128'(div_flush), 128'(0));
    check("flush_resp_clear", 128'(resp_valid), 128'(0));
    dv_lat = 3;
    issue(4'b1000, 3, 1'b0, 1'b0, 0, "after_flush");
    drain("after_flush");

    // Flush coincident with finish valid: result must be discarded.
    dv_lat = 2;
    issue(4'b0001, 0, 1'b1, 1'b0, 50, "flush_fin");
    n = 0;
    @(posedge clk); #1;
    while (!div_finish_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("flush_fin_valid", 128'(div_finish_valid), 128'(1));
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_fin_pulse", 128'(div_flush), 128'(1));
    @(posedge clk); #1;
    flush_i = 1'b0;
    sb.delete();
    // Divide by zero f16 on requester 1, presented right after the flush.
    set_req(1, 3'b001, 1'b1, 64'h3C00, 64'h0, 3'd0, 5'd31);
    req_valid = 4'b0010;
    #1;
    check("flush_fin_discard", 128'(resp_valid), 128'(0));
    issue(4'b0010, 1, 1'b0, 1'b0, 0, "f16_dz");
    check("f16_dz_exp", 128'(sb[0].rf), 128'({5'b01000, 64'h7C00}));
    check("flush_fin_discard2", 128'(resp_valid), 128'(0));
    drain("f16_dz");

    // Async reset mid-BUSY with a full buffer.
    for (int r = 0; r < N; r++) rand_req(r);
    resp_rdy = '0;
    issue(4'b1000, 3, 1'b1, 1'b0, 50, "rst_buf");
    wait_resp(4'b1000, "rst_buf_full");
    dv_lat = 20;
    issue(4'b0010, 1, 1'b1, 1'b0, 50, "rst_busy");
    @(posedge clk); #3;
    rst_n = 1'b0;
    req_valid = '0;
    sb.delete();
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_rdy = '1;
    dv_lat = 2;
    issue(4'b1111, 0, 1'b1, 1'b0, 50, "post_rst");
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
